// File: rtl/fifo_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_packer
//  Description : Pops WORDS consecutive entries from an upstream show-ahead
//                FIFO and presents them as one wide packed word with a
//                valid/ready handshake. Slot 0 of the packet (the first entry
//                popped) lands in the least-significant DATA_WIDTH bits.
//
//  Ports
//    clk         in   single clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    enable      in   permits a new packet to start (sampled in IDLE and in
//                     the OUT handshake cycle only)
//    fifo_empty  in   upstream FIFO empty flag
//    fifo_rdata  in   upstream FIFO head entry, valid while fifo_empty=0
//    fifo_rden   out  pop request to upstream FIFO (combinational)
//    out_data    out  packed word, DATA_WIDTH*WORDS bits
//    out_valid   out  out_data holds a complete packet
//    out_ready   in   downstream accepts out_data
//    busy        out  block is in any state other than IDLE
//    pkt_count   out  number of packets accepted downstream (wraps)
//
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORDS      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          fifo_empty,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata,
    output logic                          fifo_rden,
    output logic [DATA_WIDTH*WORDS-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    localparam int                IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_idx;
    logic [DATA_WIDTH*WORDS-1:0]   r_out_data;
    logic [15:0]                   r_pkt_count;
    logic                          w_pop;
    logic                          w_last_pop;
    logic                          w_handshake;

    // A pop happens on every FILL cycle the FIFO has data; an empty FIFO
    // simply stalls the fill with no timeout.
    assign w_pop       = (r_state == ST_FILL) && !fifo_empty;
    assign w_last_pop  = w_pop && (r_idx == C_LAST_IDX);
    assign w_handshake = (r_state == ST_OUT) && out_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. enable is only looked at in IDLE and on the OUT
    // handshake, so dropping it mid-FILL lets the packet complete.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = enable ? ST_FILL : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot index: advances per pop, cleared on the final slot so that
    // non-power-of-two WORDS also restart at slot 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_pop) begin
            if (w_last_pop) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet register. Each pop overwrites only its own slot; the rest of
    // the word keeps its previous contents until overwritten in turn.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
        end else if (w_pop) begin
            for (int k = 0; k < WORDS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_out_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accepted-packet counter, wraps naturally at 16 bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= 16'h0000;
        end else if (w_handshake) begin
            r_pkt_count <= r_pkt_count + 16'd1;
        end
    end

    // out_valid and busy decode straight from the state register, so the
    // asynchronous reset clears them immediately.
    assign fifo_rden = w_pop;
    assign out_data  = r_out_data;
    assign out_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_packer
//  Description : Self-checking bench for fifo_packer. A queue-based
//                show-ahead FIFO model feeds the design; expected packets
//                are queued as stimulus is written and compared when the
//                design hands a packet downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_packer;

    localparam int DW = 8;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            fifo_empty = 1'b1;
    logic [DW-1:0]   fifo_rdata = '0;
    logic            fifo_rden;
    logic [DW*W-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic [15:0]     pkt_count;

    int              n_assert = 0;
    int              n_fail   = 0;
    int              pop_cnt  = 0;
    logic [15:0]     exp_cnt  = 16'h0000;
    logic [DW*W-1:0] exp_q[$];
    logic [DW-1:0]   fq[$];
    logic [DW-1:0]   pend[$];

    fifo_packer #(.DATA_WIDTH(DW), .WORDS(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rden  (fifo_rden),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Show-ahead FIFO model: pops on rden, then absorbs newly written entries.
    always @(posedge clk) begin
        if (fifo_rden && fq.size() > 0) begin
            void'(fq.pop_front());
        end
        while (pend.size() > 0) begin
            fq.push_back(pend.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
        fifo_rdata <= (fq.size() > 0) ? fq[0] : '0;
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rden) pop_cnt++;
            check("rden_while_empty", 64'(fifo_rden & fifo_empty), 64'd0);
            if (out_valid && out_ready) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected: observed packet %h expected none", out_data);
                end
                if (exp_q.size() != 0) begin
                    check("sb_packet", out_data, exp_q.pop_front());
                end
                check("sb_pkt_count", 64'(pkt_count), 64'(exp_cnt));
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) pend.push_back(DW'(first + i));
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        n_assert++;
        assert (out_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL wait_valid_timeout: observed out_valid %b expected 1", out_valid);
        end
    endtask

    int c;
    int p0;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();

        // ---------------- reset state
        check("rst_out_data",  out_data, 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_rden",      64'(fifo_rden), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 64'(busy), 64'd0);

        // ---------------- basic packing
        out_ready = 1'b1;
        load(8'h01, 8);
        exp_q.push_back(64'h0807060504030201);
        tick();
        p0 = pop_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("basic_busy", 64'(busy), 64'd1);
        wait_valid(c);
        check("basic_latency", 64'(c), 64'd8);
        check("basic_pops",    64'(pop_cnt - p0), 64'd8);
        check("basic_data",    out_data, 64'h0807060504030201);
        tick();
        check("basic_valid_drop", 64'(out_valid), 64'd0);
        check("basic_pkt_count",  64'(pkt_count), 64'd1);
        check("basic_idle",       64'(busy), 64'd0);
        check("basic_data_held",  out_data, 64'h0807060504030201);

        // ---------------- starvation
        load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
        exp_q.push_back(64'h8877665544332211);
        tick();
        p0 = pop_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            repeat (3) tick();
            check("starve_no_valid", 64'(out_valid), 64'd0);
            load(8'h44 + 8'h11 * k, 1);
        end
        wait_valid(c);
        check("starve_pops", 64'(pop_cnt - p0), 64'd8);
        check("starve_data", out_data, 64'h8877665544332211);
        tick();
        check("starve_pkt_count", 64'(pkt_count), 64'd2);

        // ---------------- backpressure
        out_ready = 1'b0;
        load(8'h01, 16);
        exp_q.push_back(64'h0807060504030201);
        exp_q.push_back(64'h100F0E0D0C0B0A09);
        tick();
        p0 = pop_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_valid(c);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid",     64'(out_valid), 64'd1);
            check("bp_data",      out_data, 64'h0807060504030201);
            check("bp_pops",      64'(pop_cnt - p0), 64'd8);
            check("bp_pkt_count", 64'(pkt_count), 64'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_pkt_count_acc", 64'(pkt_count), 64'd3);
        check("bp_valid_drop",    64'(out_valid), 64'd0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_valid(c);
        check("bp_second_data", out_data, 64'h100F0E0D0C0B0A09);
        tick();
        check("bp_second_count", 64'(pkt_count), 64'd4);

        // ---------------- back-to-back
        load(8'h01, 16);
        exp_q.push_back(64'h0807060504030201);
        exp_q.push_back(64'h100F0E0D0C0B0A09);
        tick();
        enable = 1'b1;
        tick();
        wait_valid(c);
        check("b2b_first_latency", 64'(c), 64'd8);
        tick();
        enable = 1'b0;
        check("b2b_refill_busy", 64'(busy), 64'd1);
        check("b2b_count_mid",   64'(pkt_count), 64'd5);
        wait_valid(c);
        check("b2b_spacing", 64'(c + 1), 64'd9);
        tick();
        check("b2b_pkt_count", 64'(pkt_count), 64'd6);
        check("b2b_idle",      64'(busy), 64'd0);

        // ---------------- enable drop mid-FILL
        load(8'h01, 8);
        load(8'h21, 12);
        exp_q.push_back(64'h0807060504030201);
        tick();
        enable = 1'b1;
        tick();
        repeat (3) tick();
        enable = 1'b0;
        wait_valid(c);
        check("endrop_data", out_data, 64'h0807060504030201);
        tick();
        check("endrop_busy",  64'(busy), 64'd0);
        check("endrop_valid", 64'(out_valid), 64'd0);
        p0 = pop_cnt;
        repeat (4) tick();
        check("endrop_no_pops",  64'(pop_cnt - p0), 64'd0);
        check("endrop_pkt_count", 64'(pkt_count), 64'd7);

        // ---------------- reset mid-FILL
        enable = 1'b1;
        tick();
        enable = 1'b0;
        p0 = pop_cnt;
        repeat (4) tick();
        check("rstfill_pops", 64'(pop_cnt - p0), 64'd4);
        rst_n = 1'b0;
        #1;
        check("rstfill_out_data",  out_data, 64'd0);
        check("rstfill_valid",     64'(out_valid), 64'd0);
        check("rstfill_busy",      64'(busy), 64'd0);
        check("rstfill_pkt_count", 64'(pkt_count), 64'd0);
        check("rstfill_rden",      64'(fifo_rden), 64'd0);
        exp_cnt = 16'h0000;
        exp_q.push_back(64'h2C2B2A2928272625);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("rstfill_idle_wait", 64'(busy), 64'd0);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_valid(c);
        check("rstfill_latency", 64'(c), 64'd8);
        check("rstfill_data",    out_data, 64'h2C2B2A2928272625);
        tick();
        check("rstfill_pkt_count_after", 64'(pkt_count), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 8, which is the width of one FIFO entry.
REQ-002 The block SHALL provide parameter WORDS, default 8, which is the number of FIFO entries packed per output word (>=2).
REQ-003 The block SHALL provide port clk, input, width 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL provide port enable, input, width 1: permits a new packet to start.
REQ-006 The block SHALL provide port fifo_empty, input, width 1: empty flag from the upstream show-ahead FIFO.
REQ-007 The block SHALL provide port fifo_rdata, input, width DATA_WIDTH: head entry of the upstream FIFO, valid whenever fifo_empty=0.
REQ-008 The block SHALL provide port fifo_rden, output, width 1: pop request to the upstream FIFO.
REQ-009 The block SHALL provide port out_data, output, width DATA_WIDTH*WORDS: packed word.
REQ-010 The block SHALL provide port out_valid, output, width 1: out_data holds a complete packet.
REQ-011 The block SHALL provide port out_ready, input, width 1: downstream accepts out_data.
REQ-012 The block SHALL provide port busy, output, width 1: high in any state other than IDLE.
REQ-013 The block SHALL provide port pkt_count, output, width 16: number of packets accepted downstream.

Function
REQ-014 The block SHALL implement three states: IDLE, FILL and OUT.
REQ-015 In IDLE, the block SHALL move to FILL on a clock edge where enable=1, and otherwise stay in IDLE.
REQ-016 In FILL, fifo_rden SHALL be combinational: fifo_rden = (state==FILL) && !fifo_empty.
REQ-017 fifo_rden SHALL never be asserted while fifo_empty=1 or outside FILL.
REQ-018 On each FILL edge with fifo_rden=1, the block SHALL capture fifo_rdata into slot idx and increment idx (a ceil(log2(WORDS))-bit index).
REQ-019 Slot 0 SHALL be out_data[DATA_WIDTH-1:0] (LSB); slot k SHALL occupy bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-020 On a FILL edge with fifo_empty=1, the block SHALL stall with no capture and no idx change; there is no timeout.
REQ-021 On the edge that captures slot WORDS-1, the block SHALL clear idx to 0 and move to OUT.
REQ-022 out_valid SHALL be high from the following cycle.
REQ-023 In OUT, out_valid SHALL be 1, out_data SHALL be held stable, and fifo_rden SHALL be 0.
REQ-024 In OUT, on an edge with out_ready=1, the block SHALL increment pkt_count, drop out_valid, and go to FILL if enable=1, else to IDLE.
REQ-025 out_ready SHALL be ignored outside OUT.
REQ-026 enable SHALL be sampled only in IDLE and in the OUT handshake cycle; deasserting it mid-FILL SHALL NOT abort the packet.
REQ-027 Latency with a non-empty FIFO SHALL be: first pop in the first FILL cycle, out_valid WORDS cycles after FILL entry.
REQ-028 Throughput with out_ready=1 and enable=1 SHALL be one packet per WORDS+1 cycles.
REQ-029 pkt_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 out_data SHALL retain its last value outside OUT; bytes of the in-progress packet SHALL overwrite slots individually.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, idx=0, out_data=0, out_valid=0, pkt_count=0, busy=0.
REQ-032 fifo_rden SHALL be 0 during reset because state is IDLE.
REQ-033 A reset during FILL SHALL discard the partial packet; entries already popped are lost and SHALL NOT be re-read.
REQ-034 A reset during OUT SHALL drop the pending packet without incrementing pkt_count.
REQ-035 After rst_n rises, the block SHALL do nothing until enable=1 is sampled in IDLE.

Verification
REQ-036 The bench SHALL cover basic packing: FIFO (DEPTH 8) preloaded with 01..08, enable=1, out_ready=1 -> fifo_rden high for 8 consecutive cycles, out_data=64'h0807060504030201, out_valid for 1 cycle, pkt_count=1.
REQ-037 The bench SHALL cover starvation: preload 11,22,33, then push 44..88 one per 3 cycles -> fifo_rden never high while empty, stalls hold idx, final out_data=64'h8877665544332211.
REQ-038 The bench SHALL cover backpressure: out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable, no pops while FIFO holds 8 more entries, pkt_count increments only on the out_ready=1 edge.
REQ-039 The bench SHALL cover back-to-back packets: 16 entries 01..10, out_ready=1 -> two packets 64'h0807060504030201 then 64'h100F0E0D0C0B0A09, 9 cycles apart, pkt_count=2.
REQ-040 The bench SHALL cover the enable drop: enable=0 after 3 pops in FILL -> packet still completes; after handshake, state=IDLE, busy=0, no further pops.
REQ-041 The bench SHALL cover reset mid-FILL: rst_n low after 4 pops -> all outputs 0 immediately; after re-enable, the next packet starts from the FIFO's current head (entry 5) at slot 0.
